// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, owner encoding and lane bus.
// Used by mem_port_arbiter and mem_lane_pack.
package mem_arb_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;
    typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

    typedef logic [0:LANES-1][7:0] lane_bus_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_lane_pack.sv
// Big-endian word <-> byte-lane conversion: lane 0 carries bits 31:24.
// Write path packs the store word, read path reassembles the load word.
module mem_lane_pack
    import mem_arb_pkg::*;
(
    input  logic [31:0]            i_wr_word,
    output logic [0:LANES-1][7:0]  o_wr_lanes,
    input  logic [0:LANES-1][7:0]  i_rd_lanes,
    output logic [31:0]            o_rd_word
);

    always_comb begin
        o_wr_lanes = {i_wr_word[31:24], i_wr_word[23:16], i_wr_word[15:8], i_wr_word[7:0]};
        o_rd_word  = {i_rd_lanes[0], i_rd_lanes[1], i_rd_lanes[2], i_rd_lanes[3]};
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access,
// data has priority. Optional per-owner statistics under `MEM_ARB_STATS_EN`.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   halted,
    input  logic                   if_req,
    input  logic [ADDR_W-1:0]      if_addr,
    output logic [31:0]            if_rdata,
    output logic                   if_valid,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [ADDR_W-1:0]      d_addr,
    input  logic [31:0]            d_wdata,
    output logic [31:0]            d_rdata,
    output logic                   d_valid,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [0:LANES-1][7:0]  mem_data_in,
    output logic                   mem_write_en,
    input  logic [0:LANES-1][7:0]  mem_data_out,
    output logic                   stall,
    output logic                   busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]            stat_if_cnt,
    output logic [31:0]            stat_d_cnt,
    output logic [31:0]            stat_stall_cnt
`endif
);

    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    arb_state_t        r_state, w_state_nxt;
    arb_owner_t        r_owner, w_owner_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_we, w_we_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [31:0]       r_if_rdata, r_d_rdata;

    logic              w_capture;
    logic [31:0]       w_wr_word;
    logic [31:0]       w_rd_word;
    logic [ADDR_W-1:0] w_sel_addr;

    mem_lane_pack u_lane_pack (
        .i_wr_word  (w_wr_word),
        .o_wr_lanes (mem_data_in),
        .i_rd_lanes (mem_data_out),
        .o_rd_word  (w_rd_word)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_we_nxt     = r_we;
        w_wdata_nxt  = r_wdata;
        w_capture    = 1'b0;
        w_wr_word    = '0;
        mem_addr     = '0;
        mem_write_en = 1'b0;
        if_valid     = 1'b0;
        d_valid      = 1'b0;
        w_sel_addr   = d_req ? d_addr : if_addr;

        case (r_state)
            ARB_IDLE: begin
                if ((if_req || d_req) && !halted) begin
                    w_state_nxt = ARB_ACCESS;
                    w_cnt_nxt   = '0;
                    w_owner_nxt = d_req ? OWN_D : OWN_IF;
                    w_addr_nxt  = w_sel_addr & ~ADDR_W'(3);
                    w_we_nxt    = d_req && d_we;
                    w_wdata_nxt = d_wdata;
                end
            end
            ARB_ACCESS: begin
                mem_addr     = r_addr;
                mem_write_en = r_we && (r_cnt == '0);
                if (r_we) begin
                    w_wr_word = r_wdata;
                end
                if (r_cnt == LAST_CNT) begin
                    w_capture   = !r_we;
                    w_state_nxt = ARB_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ARB_DONE: begin
                // No grant here: the bubble keeps back-to-back ordering simple.
                if_valid    = (r_owner == OWN_IF);
                d_valid     = (r_owner == OWN_D);
                w_state_nxt = ARB_IDLE;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_state    <= ARB_IDLE;
            r_owner    <= OWN_IF;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_we    <= w_we_nxt;
            r_wdata <= w_wdata_nxt;
            if (w_capture) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= w_rd_word;
                end else begin
                    r_d_rdata <= w_rd_word;
                end
            end
        end
    end

    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;
    assign stall    = (if_req || d_req) && !(if_valid || d_valid);
    assign busy     = (r_state != ARB_IDLE);

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_stat_if, r_stat_d, r_stat_stall;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_stat_if    <= '0;
            r_stat_d     <= '0;
            r_stat_stall <= '0;
        end else begin
            if (if_valid) r_stat_if    <= sat_inc(r_stat_if);
            if (d_valid)  r_stat_d     <= sat_inc(r_stat_d);
            if (stall)    r_stat_stall <= sat_inc(r_stat_stall);
        end
    end

    assign stat_if_cnt    = r_stat_if;
    assign stat_d_cnt     = r_stat_d;
    assign stat_stall_cnt = r_stat_stall;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of mem_port_arbiter against a cycle-phase reference model.
// Statistics outputs are checked when built with `MEM_ARB_STATS_EN`.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned L  = 2;
    localparam int unsigned AW = 32;

    logic            clk = 1'b0;
    logic            rst_b = 1'b1;
    logic            halted = 1'b0;
    logic            if_req = 1'b0;
    logic [AW-1:0]   if_addr = '0;
    logic [31:0]     if_rdata;
    logic            if_valid;
    logic            d_req = 1'b0;
    logic            d_we = 1'b0;
    logic [AW-1:0]   d_addr = '0;
    logic [31:0]     d_wdata = '0;
    logic [31:0]     d_rdata;
    logic            d_valid;
    logic [AW-1:0]   mem_addr;
    logic [0:3][7:0] mem_data_in;
    logic            mem_write_en;
    logic [0:3][7:0] mem_data_out;
    logic            stall;
    logic            busy;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]     stat_if_cnt, stat_d_cnt, stat_stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .halted       (halted),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_valid     (if_valid),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_valid      (d_valid),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out),
        .stall        (stall),
        .busy         (busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_cnt    (stat_if_cnt),
        .stat_d_cnt     (stat_d_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    // Memory seen by the DUT, and the model's own view of what it should hold.
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] rd_word;
    int          wr_cnt = 0;

    assign rd_word      = mem[mem_addr[7:2]];
    assign mem_data_out = {rd_word[31:24], rd_word[23:16], rd_word[15:8], rd_word[7:0]};

    always @(posedge clk) begin
        if (mem_write_en === 1'b1) begin
            mem[mem_addr[7:2]] = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
            wr_cnt++;
        end
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endfunction

    // Reference model: a transaction granted in cycle g occupies cycles g+1..g+L
    // on the port, reports completion in cycle g+L+1, and frees the port after that.
    int          cyc = 0;
    bit          m_active = 0;
    int          m_grant = 0;
    bit          m_own_d = 0;
    bit          m_we = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata = '0;
    int          exp_if_n = 0;
    int          exp_d_n = 0;
    int          exp_stall_n = 0;

    bit          saw_if = 0;
    bit          saw_d = 0;
    bit          if_pend = 0;
    bit          d_pend = 0;
    bit          rand_en = 0;
    logic [31:0] cap_addr = '0;
    logic [0:3][7:0] cap_lanes = '0;

    task automatic check_cycle();
        int ph;
        bit acc, done, idle, exp_stall;
        ph   = cyc - m_grant;
        acc  = m_active && ph >= 1 && ph <= int'(L);
        done = m_active && ph == int'(L) + 1;
        idle = !(acc || done);
        if (done) begin
            if (m_we) begin
                ref_mem[m_addr[7:2]] = m_wdata;
                chk("store_commit", mem[m_addr[7:2]], m_wdata);
            end else if (m_own_d) begin
                exp_d_rdata = ref_mem[m_addr[7:2]];
            end else begin
                exp_if_rdata = ref_mem[m_addr[7:2]];
            end
            if (m_own_d) exp_d_n++;
            else         exp_if_n++;
        end
        exp_stall = (if_req || d_req) && !done;
        if (exp_stall) exp_stall_n++;

        chk("busy",        32'(busy),         32'(acc || done));
        chk("mem_addr",    mem_addr,          acc ? m_addr : 32'h0);
        chk("mem_we",      32'(mem_write_en), 32'(acc && m_we && ph == 1));
        chk("mem_data_in", mem_data_in,       (acc && m_we) ? m_wdata : 32'h0);
        chk("if_valid",    32'(if_valid),     32'(done && !m_own_d));
        chk("d_valid",     32'(d_valid),      32'(done && m_own_d));
        chk("stall",       32'(stall),        32'(exp_stall));
        chk("if_rdata",    if_rdata,          exp_if_rdata);
        chk("d_rdata",     d_rdata,           exp_d_rdata);

        saw_if = (if_valid === 1'b1);
        saw_d  = (d_valid === 1'b1);
        if (mem_write_en === 1'b1) begin
            cap_addr  = mem_addr;
            cap_lanes = mem_data_in;
        end

        if (idle) m_active = 0;
        if (idle && (if_req || d_req) && !halted) begin
            m_active = 1;
            m_grant  = cyc;
            m_own_d  = d_req;
            m_addr   = (d_req ? d_addr : if_addr) & ~32'h3;
            m_we     = d_req && d_we;
            m_wdata  = d_wdata;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (if_pend && saw_if) begin if_pend = 0; if_req = 1'b0; end
        if (d_pend && saw_d)   begin d_pend = 0;  d_req = 1'b0;  end
        if (rand_en) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_req = 1'b1; if_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_req = 1'b1; d_addr = $urandom;
                d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end
            if ($urandom_range(0, 15) == 0) halted = !halted;
        end
    endtask

    // Steps until both requesters are served; records the step index of each valid.
    task automatic drain(input int max, output int n_if, output int n_d);
        int n;
        n = 0; n_if = -1; n_d = -1;
        while ((if_pend || d_pend) && n < max) begin
            step();
            n++;
            if (saw_if) n_if = n;
            if (saw_d)  n_d  = n;
        end
        chk("drain_timeout", 32'({if_pend, d_pend}), 32'h0);
    endtask

    task automatic model_reset();
        m_active     = 0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        exp_if_n     = 0;
        exp_d_n      = 0;
        exp_stall_n  = 0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy),         32'h0);
        chk({tag, "_we"},    32'(mem_write_en), 32'h0);
        chk({tag, "_addr"},  mem_addr,          32'h0);
        chk({tag, "_wdata"}, mem_data_in,       32'h0);
        chk({tag, "_ifv"},   32'(if_valid),     32'h0);
        chk({tag, "_dv"},    32'(d_valid),      32'h0);
        chk({tag, "_ifrd"},  if_rdata,          32'h0);
        chk({tag, "_drd"},   d_rdata,           32'h0);
    endtask

    initial begin
        int a, b, w0;
        logic [31:0] d40;

        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4]     = 32'h2002_0005;
        ref_mem[4] = 32'h2002_0005;
        d40        = mem[16];

        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_stall", 32'(stall), 32'h0);
        rst_b = 1'b0;

        // Fetch only.
        if_addr = 32'h0000_0010; if_req = 1'b1; if_pend = 1;
        drain(20, a, b);
        chk("if_only_lat",   32'(a), 32'(L + 2));
        chk("if_only_rdata", if_rdata, 32'h2002_0005);

        // Simultaneous fetch and load: data first, fetch L+2 cycles later.
        if_addr = 32'h0000_0010; if_req = 1'b1; if_pend = 1;
        d_addr = 32'h0000_0040; d_we = 1'b0; d_req = 1'b1; d_pend = 1;
        drain(30, a, b);
        chk("simul_d_lat",   32'(b), 32'(L + 2));
        chk("simul_gap",     32'(a - b), 32'(L + 2));
        chk("simul_d_rdata", d_rdata, d40);

        // Unaligned store.
        d_addr = 32'h0000_0023; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1; d_pend = 1;
        w0 = wr_cnt;
        drain(20, a, b);
        chk("store_lat",     32'(b), 32'(L + 2));
        chk("store_strobes", 32'(wr_cnt - w0), 32'h1);
        chk("store_addr",    cap_addr, 32'h0000_0020);
        chk("store_lane0",   32'(cap_lanes[0]), 32'hDE);
        chk("store_lane3",   32'(cap_lanes[3]), 32'hEF);

        // Halt raised mid-load: load completes, later fetch never granted.
        d_addr = 32'h0000_0044; d_we = 1'b0; d_req = 1'b1; d_pend = 1;
        step();
        step();
        halted = 1'b1;
        drain(20, a, b);
        chk("halt_load_done", 32'(b), 32'(L));
        if_addr = 32'h0000_0080; if_req = 1'b1; if_pend = 1;
        repeat (10) step();
        chk("halt_if_held", 32'(if_pend), 32'h1);
        chk("halt_busy",    32'(busy), 32'h0);
        halted = 1'b0;
        drain(20, a, b);
        chk("unhalt_if_rdata", if_rdata, ref_mem[32]);

        // Reset during the first cycle of a store.
        d_addr = 32'h0000_0030; d_we = 1'b1; d_wdata = $urandom; d_req = 1'b1; d_pend = 1;
        step();
        chk("pre_rst_we", 32'(mem_write_en), 32'h1);
        w0 = wr_cnt;
        #2;
        rst_b = 1'b1; d_req = 1'b0; d_pend = 0;
        #1;
        chk_idle_outputs("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_strobe", 32'(wr_cnt - w0), 32'h0);
        chk("rst_mem_kept",  mem[12], ref_mem[12]);
        rst_b = 1'b0;

        // Three fetches and two loads after reset.
        for (int k = 0; k < 3; k++) begin
            if_addr = 32'(k * 4 + 32'h0000_0090); if_req = 1'b1; if_pend = 1;
            drain(20, a, b);
            if (k == 0) chk("post_rst_lat", 32'(a), 32'(L + 2));
        end
        for (int k = 0; k < 2; k++) begin
            d_addr = 32'(k * 4 + 32'h0000_00A0); d_we = 1'b0; d_req = 1'b1; d_pend = 1;
            drain(20, a, b);
        end
`ifdef MEM_ARB_STATS_EN
        chk("stat_if_5",    stat_if_cnt,    32'h3);
        chk("stat_d_5",     stat_d_cnt,     32'h2);
        chk("stat_stall_5", stat_stall_cnt, 32'(exp_stall_n));
`endif

        // Random traffic with occasional halts.
        rand_en = 1;
        repeat (400) step();
        rand_en = 0;
        halted  = 1'b0;
        drain(40, a, b);
        for (int i = 0; i < 64; i++) begin
            chk("final_mem", mem[i], ref_mem[i]);
        end
`ifdef MEM_ARB_STATS_EN
        chk("stat_if",    stat_if_cnt,    32'(exp_if_n));
        chk("stat_d",     stat_d_cnt,     32'(exp_d_n));
        chk("stat_stall", stat_stall_cnt, 32'(exp_stall_n));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
